pipelined_cla_alu: RTL and testbench

PIPELINED_CLA_ALU -- requirements
Module: pipelined_cla_alu

---
 rtl/cla_alu_pkg.sv | 14 +
 rtl/cla_group.sv | 33 +++
 rtl/pipelined_cla_alu.sv | 174 +++++++++++++++++
 tb/tb_pipelined_cla_alu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_alu_pkg.sv
// Shared definitions for the pipelined carry-lookahead ALU: operation
// encodings and the lookahead group width.
package cla_alu_pkg;

    localparam int CLA_GROUP = 4;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_SLT  = 2'b10,
        ALU_SLTU = 2'b11
    } alu_op_e;

endpackage

// File: rtl/cla_group.sv
// 4-bit carry-lookahead group: produces the group sum plus the group
// generate/propagate terms used to chain groups together.
module cla_group
    import cla_alu_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a,
    input  logic [CLA_GROUP-1:0] b,
    input  logic                 cin,
    output logic [CLA_GROUP-1:0] sum,
    output logic                 g,
    output logic                 p
);

    logic [CLA_GROUP-1:0] gen;
    logic [CLA_GROUP-1:0] prop;
    logic [CLA_GROUP-1:0] carry;

    // Every internal carry is expanded from the group inputs so no bit waits on its neighbour
    always_comb begin
        gen      = a & b;
        prop     = a ^ b;
        carry[0] = cin;
        carry[1] = gen[0] | (prop[0] & cin);
        carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
        carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                 | (prop[2] & prop[1] & prop[0] & cin);
        sum      = prop ^ carry;
        g        = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0]);
        p        = &prop;
    end

endmodule

// File: rtl/pipelined_cla_alu.sv
// Pipelined carry-lookahead ADD/SUB/SLT/SLTU unit. Each of the STAGES stages
// adds WIDTH/STAGES bits; the carry between slices is registered, and the
// operand slices not yet consumed ride along in skew registers so a new
// operation can enter every non-stalled cycle. WIDTH must be a multiple of
// 4*STAGES.
// Optional feature: define PIPELINED_CLA_ALU_FLAGS_EN to get registered
// c_out/ovf/zero flags; otherwise those outputs are tied low.
module pipelined_cla_alu
    import cla_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       ALUctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int NGRP  = SLICE / CLA_GROUP;
    localparam int LAST  = STAGES - 1;

    // Everything except ADD subtracts: invert b here and inject the +1 as carry-in
    logic             sub_op;
    logic [WIDTH-1:0] b_eff;

    assign sub_op = (ALUctl != ALU_ADD);
    assign b_eff  = sub_op ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits this stage still carries: its own slice plus all higher slices
        localparam int REM = WIDTH - k * SLICE;

        logic                   st_valid;
        alu_op_e                st_op;
        logic                   st_cin;
        logic [REM-1:0]         st_a;
        logic [REM-1:0]         st_b;
        logic [SLICE-1:0]       slice_sum;
        logic [NGRP:0]          gc;
        logic [NGRP-1:0]        grp_g;
        logic [NGRP-1:0]        grp_p;
        logic [(k+1)*SLICE-1:0] sum_acc;

        if (k == 0) begin : g_first
            assign st_valid = in_valid;
            assign st_op    = alu_op_e'(ALUctl);
            assign st_cin   = sub_op;
            assign st_a     = a;
            assign st_b     = b_eff;
            assign sum_acc  = slice_sum;
        end else begin : g_rest
            logic                 valid_q;
            alu_op_e              op_q;
            logic                 cin_q;
            logic [REM-1:0]       a_q;
            logic [REM-1:0]       b_q;
            logic [k*SLICE-1:0]   sum_q;

            // Valid bit: flush beats stall, stall freezes, otherwise follow the previous stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (!stall) begin
                    valid_q <= g_stage[k-1].st_valid;
                end
            end

            // Skew registers: slice carry, finished low sum bits and the unconsumed operand slices
            always_ff @(posedge clk) begin
                if (!stall) begin
                    op_q  <= g_stage[k-1].st_op;
                    cin_q <= g_stage[k-1].gc[NGRP];
                    a_q   <= g_stage[k-1].st_a[REM+SLICE-1:SLICE];
                    b_q   <= g_stage[k-1].st_b[REM+SLICE-1:SLICE];
                    sum_q <= g_stage[k-1].sum_acc;
                end
            end

            assign st_valid = valid_q;
            assign st_op    = op_q;
            assign st_cin   = cin_q;
            assign st_a     = a_q;
            assign st_b     = b_q;
            assign sum_acc  = {slice_sum, sum_q};
        end

        assign gc[0] = st_cin;

        for (genvar j = 0; j < NGRP; j++) begin : g_grp
            cla_group u_grp (
                .a   (st_a[j*CLA_GROUP +: CLA_GROUP]),
                .b   (st_b[j*CLA_GROUP +: CLA_GROUP]),
                .cin (gc[j]),
                .sum (slice_sum[j*CLA_GROUP +: CLA_GROUP]),
                .g   (grp_g[j]),
                .p   (grp_p[j])
            );
            assign gc[j+1] = grp_g[j] | (grp_p[j] & gc[j]);
        end
    end

    logic [WIDTH-1:0] fin_sum;
    logic             fin_cout;
    logic             fin_ovf;
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] result;

    assign fin_sum  = g_stage[LAST].sum_acc;
    assign fin_cout = g_stage[LAST].gc[NGRP];
    assign a_msb    = g_stage[LAST].st_a[SLICE-1];
    assign b_msb    = g_stage[LAST].st_b[SLICE-1];
    assign fin_ovf  = (a_msb == b_msb) && (fin_sum[WIDTH-1] != a_msb);

    // Pick the architectural result; compares reduce to a single LSB
    always_comb begin
        result = fin_sum;
        case (g_stage[LAST].st_op)
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, fin_sum[WIDTH-1] ^ fin_ovf};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, ~fin_cout};
            default:  result = fin_sum;
        endcase
    end

    // Output register: flush drops the valid flag, stall holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (!stall) begin
                out_valid <= g_stage[LAST].st_valid;
            end
            if (!stall) begin
                s <= result;
            end
        end
    end

`ifdef PIPELINED_CLA_ALU_FLAGS_EN
    // Flag registers track the result register and hold with it under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (!stall) begin
            c_out <= fin_cout;
            ovf   <= fin_ovf;
            zero  <= (result == '0);
        end
    end
`else
    assign c_out = 1'b0;
    assign ovf   = 1'b0;
    assign zero  = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_alu.sv
// Self-checking bench for pipelined_cla_alu: a 32-bit/2-stage and a
// 64-bit/4-stage instance, each checked against an arithmetic reference
// model. Flag expectations follow PIPELINED_CLA_ALU_FLAGS_EN.
module tb_pipelined_cla_alu;
    import cla_alu_pkg::*;

    typedef struct {
        logic        v;
        logic [63:0] s;
        logic        c;
        logic        o;
    } slot_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        iv32, st32, fl32, ov32, c32, o32, z32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, s32;

    logic        iv64, st64, fl64, ov64, c64, o64, z64;
    logic [1:0]  op64;
    logic [63:0] a64, b64, s64;

    int tests_run    = 0;
    int tests_failed = 0;

    slot_t m32 [2];
    slot_t m64 [4];

    int bb_a [11] = '{0, 1, 7, 7, 7, 2, 3, 4, 0, 0, 0};

    always #5 clk = ~clk;

    pipelined_cla_alu #(.WIDTH(32), .STAGES(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .ALUctl(op32), .a(a32), .b(b32),
        .stall(st32), .flush(fl32), .out_valid(ov32), .s(s32), .c_out(c32), .ovf(o32), .zero(z32)
    );

    pipelined_cla_alu #(.WIDTH(64), .STAGES(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .ALUctl(op64), .a(a64), .b(b64),
        .stall(st64), .flush(fl64), .out_valid(ov64), .s(s64), .c_out(c64), .ovf(o64), .zero(z64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [65:0] sx(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = $signed(v << (64 - w));
        t = t >>> (64 - w);
        return $signed({{2{t[63]}}, t});
    endfunction

    // Reference: plain signed/unsigned arithmetic on the w-bit operands
    function automatic slot_t ref_op(input int w, input logic [1:0] op,
                                     input logic [63:0] a, input logic [63:0] b);
        slot_t r;
        logic [63:0] mask;
        logic [64:0] ua, ub, usum;
        logic signed [65:0] sa, sb, res;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        ua   = {1'b0, a & mask};
        ub   = {1'b0, b & mask};
        sa   = sx(a, w);
        sb   = sx(b, w);
        usum = ua + ub;
        if (op == ALU_ADD) begin
            res = sa + sb;
            r.c = usum[w];
        end else begin
            res = sa - sb;
            r.c = (ua >= ub);
        end
        r.o = (res != sx(res[63:0], w));
        case (op)
            ALU_SLT:  r.s = {63'd0, (sa < sb)};
            ALU_SLTU: r.s = {63'd0, (ua < ub)};
            default:  r.s = res[63:0] & mask;
        endcase
        r.v = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] rnd_operand(input int w);
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'd1 << (w - 1);
            3: v = (64'd1 << (w - 1)) - 64'd1;
            default: ;
        endcase
        if (w < 64) v = v & ((64'd1 << w) - 64'd1);
        return v;
    endfunction

    task automatic clearModels();
        foreach (m32[i]) m32[i].v = 1'b0;
        foreach (m64[i]) m64[i].v = 1'b0;
    endtask

    task automatic resetCheck(input string tag);
        chk({tag, " out_valid32"}, {63'd0, ov32}, 64'd0);
        chk({tag, " s32"}, {32'd0, s32}, 64'd0);
        chk({tag, " flags32"}, {61'd0, c32, o32, z32}, 64'd0);
        chk({tag, " out_valid64"}, {63'd0, ov64}, 64'd0);
        chk({tag, " s64"}, s64, 64'd0);
        chk({tag, " flags64"}, {61'd0, c64, o64, z64}, 64'd0);
    endtask

    task automatic checkOutput(input logic sel64);
        slot_t e;
        logic [63:0] obs_s;
        logic ov, c, o, z;
        if (sel64) begin
            e = m64[3]; ov = ov64; obs_s = s64; c = c64; o = o64; z = z64;
        end else begin
            e = m32[1]; ov = ov32; obs_s = {32'd0, s32}; c = c32; o = o32; z = z32;
        end
        chk(sel64 ? "out_valid64" : "out_valid32", {63'd0, ov}, {63'd0, e.v});
        if (e.v) chk(sel64 ? "s64" : "s32", obs_s, e.s);
`ifdef PIPELINED_CLA_ALU_FLAGS_EN
        if (e.v) begin
            chk(sel64 ? "c_out64" : "c_out32", {63'd0, c}, {63'd0, e.c});
            chk(sel64 ? "ovf64" : "ovf32", {63'd0, o}, {63'd0, e.o});
            chk(sel64 ? "zero64" : "zero32", {63'd0, z}, {63'd0, (e.s == 64'd0)});
        end
`else
        chk(sel64 ? "tied flags64" : "tied flags32", {61'd0, c, o, z}, 64'd0);
`endif
    endtask

    task automatic applyStimulus(input logic sel64, input logic iv, input logic [1:0] op,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic st, input logic fl);
        iv32 = 1'b0; st32 = 1'b0; fl32 = 1'b0;
        iv64 = 1'b0; st64 = 1'b0; fl64 = 1'b0;
        if (sel64) begin
            iv64 = iv; op64 = op; a64 = a; b64 = b; st64 = st; fl64 = fl;
        end else begin
            iv32 = iv; op32 = op; a32 = a[31:0]; b32 = b[31:0]; st32 = st; fl32 = fl;
        end
        @(posedge clk);
        if (fl32) begin
            foreach (m32[i]) m32[i].v = 1'b0;
        end else if (!st32) begin
            m32[1] = m32[0];
            m32[0] = ref_op(32, op32, {32'd0, a32}, {32'd0, b32});
            m32[0].v = iv32;
        end
        if (fl64) begin
            foreach (m64[i]) m64[i].v = 1'b0;
        end else if (!st64) begin
            for (int i = 3; i > 0; i--) m64[i] = m64[i-1];
            m64[0] = ref_op(64, op64, a64, b64);
            m64[0].v = iv64;
        end
        #1;
        checkOutput(sel64);
    endtask

    task automatic idle(input logic sel64, input int n);
        repeat (n) applyStimulus(sel64, 1'b0, ALU_ADD, 64'd0, 64'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] got [$];
        logic [63:0] ra, rb;

        iv32 = 0; st32 = 0; fl32 = 0; op32 = 0; a32 = 0; b32 = 0;
        iv64 = 0; st64 = 0; fl64 = 0; op64 = 0; a64 = 0; b64 = 0;
        rst_n = 1'b0;
        clearModels();
        repeat (2) @(posedge clk);
        #1;
        resetCheck("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed ADD/SUB/SLT/SLTU");
        applyStimulus(0, 1, ALU_ADD, 64'hFFFF_FFFF, 64'd1, 0, 0);
        idle(0, 1);
        chk("add wrap s", {32'd0, s32}, 64'd0);
        applyStimulus(0, 1, ALU_SUB, 64'h8000_0000, 64'd1, 0, 0);
        idle(0, 1);
        chk("sub ovf s", {32'd0, s32}, 64'h7FFF_FFFF);
        applyStimulus(0, 1, ALU_SLT, 64'hFFFF_FFFF, 64'd1, 0, 0);
        applyStimulus(0, 1, ALU_SLTU, 64'hFFFF_FFFF, 64'd1, 0, 0);
        chk("slt s", {32'd0, s32}, 64'd1);
        idle(0, 1);
        chk("sltu s", {32'd0, s32}, 64'd0);
        idle(0, 1);

        $display("[TB] back-to-back with stall");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(0, (i < 8), ALU_ADD, 64'(bb_a[i]), 64'(bb_a[i]), (i >= 2 && i <= 4), 0);
            if (ov32 && !(i >= 2 && i <= 4)) got.push_back({32'd0, s32});
        end
        chk("b2b count", 64'(got.size()), 64'd5);
        for (int i = 0; i < got.size() && i < 5; i++)
            chk($sformatf("b2b result %0d", i), got[i], 64'(2 * i));

        $display("[TB] flush cases");
        applyStimulus(0, 1, ALU_ADD, 64'd5, 64'd5, 0, 0);
        applyStimulus(0, 0, ALU_ADD, 64'd0, 64'd0, 0, 1);
        idle(0, 3);
        applyStimulus(0, 1, ALU_ADD, 64'd6, 64'd6, 0, 1);
        idle(0, 2);
        applyStimulus(0, 1, ALU_SUB, 64'd9, 64'd2, 0, 0);
        applyStimulus(0, 0, ALU_ADD, 64'd0, 64'd0, 1, 1);
        idle(0, 2);

        $display("[TB] reset mid-pipeline");
        applyStimulus(0, 1, ALU_ADD, 64'd9, 64'd9, 0, 0);
        applyStimulus(0, 1, ALU_SUB, 64'd2, 64'd1, 0, 0);
        #2 rst_n = 1'b0;
        #1 resetCheck("async reset");
        clearModels();
        @(negedge clk);
        rst_n = 1'b1;
        idle(0, 3);
        applyStimulus(0, 1, ALU_ADD, 64'd3, 64'd4, 0, 0);
        idle(0, 1);
        chk("post reset s", {32'd0, s32}, 64'd7);

        $display("[TB] random 32-bit");
        for (int i = 0; i < 200; i++) begin
            ra = rnd_operand(32);
            rb = rnd_operand(32);
            applyStimulus(0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ra, rb,
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
        end
        idle(0, 3);

        $display("[TB] 64-bit / 4-stage");
        applyStimulus(1, 1, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0);
        idle(1, 3);
        chk("add64 wrap s", s64, 64'd0);
        applyStimulus(1, 1, ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 0, 0);
        idle(1, 3);
        chk("sub64 s", s64, 64'h7FFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 150; i++) begin
            ra = rnd_operand(64);
            rb = rnd_operand(64);
            applyStimulus(1, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ra, rb,
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
        end
        idle(1, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
